// File: rtl/hazard_ctrl_206_if.sv
// Hazard controller bus: the pipeline-side requests and the stall/flush controls.
// With HAZ_STAT_EN defined, the stall_cycles/flush_events statistics outputs are added.
interface hazard_ctrl_206_if;
    logic [4:0]  rs_ID;
    logic [4:0]  rt_ID;
    logic        rs_used_ID;
    logic        rt_used_ID;
    logic [4:0]  rw_Ex;
    logic        RegWr_Ex;
    logic        MemToReg_Ex;
    logic        Branch_taken_Ex;
    logic        Jump_Ex;
    logic        md_start_Ex;
    logic        mem_req_Mem;
    logic        mem_ready;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_stall;
    logic        id_ex_flush;
    logic        ex_mem_stall;
    logic        ex_mem_flush;
    logic        mem_wb_flush;
    logic        md_busy;
    logic        md_done;
    logic        mem_timeout;
`ifdef HAZ_STAT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    modport master (
        output rs_ID, rt_ID, rs_used_ID, rt_used_ID, rw_Ex, RegWr_Ex, MemToReg_Ex,
               Branch_taken_Ex, Jump_Ex, md_start_Ex, mem_req_Mem, mem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
               ex_mem_flush, mem_wb_flush, md_busy, md_done, mem_timeout
`ifdef HAZ_STAT_EN
        , input stall_cycles, flush_events
`endif
    );

    modport slave (
        input  rs_ID, rt_ID, rs_used_ID, rt_used_ID, rw_Ex, RegWr_Ex, MemToReg_Ex,
               Branch_taken_Ex, Jump_Ex, md_start_Ex, mem_req_Mem, mem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
               ex_mem_flush, mem_wb_flush, md_busy, md_done, mem_timeout
`ifdef HAZ_STAT_EN
        , output stall_cycles, flush_events
`endif
    );
endinterface

// File: rtl/hazard_ctrl_206.sv
// Pipeline hazard/stall controller: load-use interlock, redirect squash, mult/div occupancy
// of EX, memory-wait freeze and sticky timeout. HAZ_STAT_EN adds stall/flush statistics.
module hazard_ctrl_206 #(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned MEM_TO = 16
) (
    input logic             clk,
    input logic             rst_n,
    hazard_ctrl_206_if.slave bus
);
    typedef enum logic [0:0] {StRun, StMd} state_t;

    localparam logic [5:0] MdLoad  = 6'(MD_LAT - 2);
    localparam logic [7:0] WaitMax = 8'(MEM_TO);
    localparam logic [7:0] WaitHit = 8'(MEM_TO - 1);

    state_t     state_q;
    logic [5:0] md_cnt_q;
    logic [7:0] wait_cnt_q;
    logic       timeout_q;

    logic ld_use, freeze, redirect, timeout_hit;
    logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_flush_c;
    logic ex_mem_stall_c, ex_mem_flush_c, mem_wb_flush_c, md_busy_c, md_done_c;

    assign ld_use = bus.RegWr_Ex & bus.MemToReg_Ex & (bus.rw_Ex != 5'd0) &
                    ((bus.rs_used_ID & (bus.rs_ID == bus.rw_Ex)) |
                     (bus.rt_used_ID & (bus.rt_ID == bus.rw_Ex)));
    assign freeze      = bus.mem_req_Mem & ~bus.mem_ready;
    assign redirect    = bus.Branch_taken_Ex | bus.Jump_Ex;
    assign timeout_hit = freeze & (wait_cnt_q == WaitHit);

    always_comb begin
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_stall_c = 1'b0;
        ex_mem_flush_c = 1'b0;
        mem_wb_flush_c = 1'b0;
        md_busy_c      = 1'b0;
        md_done_c      = 1'b0;
        unique case (state_q)
            StRun: begin
                if (freeze) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                    mem_wb_flush_c = 1'b1;
                end else if (bus.md_start_Ex) begin
                    md_busy_c      = 1'b1;
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_stall_c  = 1'b1;
                    ex_mem_flush_c = 1'b1;
                end else if (redirect) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (ld_use) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
            end
            StMd: begin
                md_busy_c = 1'b1;
                if (md_cnt_q != 6'd0) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_stall_c  = 1'b1;
                    ex_mem_flush_c = 1'b1;
                    ex_mem_stall_c = freeze;
                    mem_wb_flush_c = freeze;
                end else if (freeze) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                    mem_wb_flush_c = 1'b1;
                end else begin
                    md_done_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs are Mealy, so they are gated by rst_n to stay low while reset is held.
    assign bus.pc_stall     = rst_n & pc_stall_c;
    assign bus.if_id_stall  = rst_n & if_id_stall_c;
    assign bus.if_id_flush  = rst_n & if_id_flush_c;
    assign bus.id_ex_stall  = rst_n & id_ex_stall_c;
    assign bus.id_ex_flush  = rst_n & id_ex_flush_c;
    assign bus.ex_mem_stall = rst_n & ex_mem_stall_c;
    assign bus.ex_mem_flush = rst_n & ex_mem_flush_c;
    assign bus.mem_wb_flush = rst_n & mem_wb_flush_c;
    assign bus.md_busy      = rst_n & md_busy_c;
    assign bus.md_done      = rst_n & md_done_c;
    assign bus.mem_timeout  = rst_n & (timeout_q | timeout_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            md_cnt_q   <= 6'd0;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (!freeze && bus.md_start_Ex) begin
                        state_q  <= StMd;
                        md_cnt_q <= MdLoad;
                    end
                end
                StMd: begin
                    if (md_cnt_q != 6'd0) begin
                        md_cnt_q <= md_cnt_q - 6'd1;
                    end else if (!freeze) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
            if (!freeze) begin
                wait_cnt_q <= 8'd0;
            end else if (wait_cnt_q != WaitMax) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            timeout_q <= timeout_q | timeout_hit;
        end
    end

`ifdef HAZ_STAT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            if (bus.pc_stall) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (bus.if_id_flush) flush_events_q <= flush_events_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_events = flush_events_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl_206.sv
// Directed bench for hazard_ctrl_206 with MD_LAT=4, MEM_TO=4; expected output vectors
// are hand-derived per cycle.
module tb_hazard_ctrl_206;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_206_if bus ();

    hazard_ctrl_206 #(
        .MD_LAT(4),
        .MEM_TO(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Output vector bit positions.
    localparam logic [10:0] PC   = 11'h400;
    localparam logic [10:0] IFS  = 11'h200;
    localparam logic [10:0] IFF  = 11'h100;
    localparam logic [10:0] IDS  = 11'h080;
    localparam logic [10:0] IDF  = 11'h040;
    localparam logic [10:0] EMS  = 11'h020;
    localparam logic [10:0] EMF  = 11'h010;
    localparam logic [10:0] MWF  = 11'h008;
    localparam logic [10:0] BUSY = 11'h004;
    localparam logic [10:0] DONE = 11'h002;
    localparam logic [10:0] TO   = 11'h001;
    localparam logic [10:0] NONE = 11'h000;
    localparam logic [10:0] LU   = PC | IFS | IDF;
    localparam logic [10:0] RD   = IFF | IDF;
    localparam logic [10:0] MDS  = BUSY | PC | IFS | IDS | EMF;
    localparam logic [10:0] FRZ  = PC | IFS | IDS | EMS | MWF;

    function automatic logic [10:0] outs();
        return {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
                bus.id_ex_flush, bus.ex_mem_stall, bus.ex_mem_flush, bus.mem_wb_flush,
                bus.md_busy, bus.md_done, bus.mem_timeout};
    endfunction

    task automatic chk(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        #2;
        obs = outs();
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.rs_ID = 5'd0;
        bus.rt_ID = 5'd0;
        bus.rs_used_ID = 1'b0;
        bus.rt_used_ID = 1'b0;
        bus.rw_Ex = 5'd0;
        bus.RegWr_Ex = 1'b0;
        bus.MemToReg_Ex = 1'b0;
        bus.Branch_taken_Ex = 1'b0;
        bus.Jump_Ex = 1'b0;
        bus.md_start_Ex = 1'b0;
        bus.mem_req_Mem = 1'b0;
        bus.mem_ready = 1'b1;
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;
        // Load-use pattern present during reset must not leak out.
        bus.RegWr_Ex = 1'b1; bus.MemToReg_Ex = 1'b1; bus.rw_Ex = 5'd8;
        bus.rs_ID = 5'd8; bus.rs_used_ID = 1'b1;
        cyc(); chk("reset_gated", NONE);
        clr_in();
        cyc(); rst_n = 1'b1; chk("reset_idle", NONE);

        // Load-use interlock
        cyc(); bus.RegWr_Ex = 1'b1; bus.MemToReg_Ex = 1'b1; bus.rw_Ex = 5'd8;
        bus.rs_ID = 5'd8; bus.rs_used_ID = 1'b1; chk("lu_rs", LU);
        cyc(); bus.rw_Ex = 5'd9; chk("lu_miss", NONE);
        cyc(); bus.rw_Ex = 5'd0; bus.rs_ID = 5'd0; chk("lu_r0", NONE);
        cyc(); bus.rw_Ex = 5'd8; bus.rs_ID = 5'd0; bus.rs_used_ID = 1'b0;
        bus.rt_ID = 5'd8; bus.rt_used_ID = 1'b1; chk("lu_rt", LU);
        cyc(); bus.rt_used_ID = 1'b0; chk("lu_rt_unused", NONE);
        cyc(); bus.rt_used_ID = 1'b1; bus.MemToReg_Ex = 1'b0; chk("lu_not_load", NONE);

        // Redirect beats load-use
        cyc(); bus.MemToReg_Ex = 1'b1; bus.Branch_taken_Ex = 1'b1; chk("br_over_lu", RD);
        cyc(); clr_in(); bus.Jump_Ex = 1'b1; chk("jump", RD);

        // Mult/div, MD_LAT=4, start held high
        cyc(); clr_in(); bus.md_start_Ex = 1'b1; chk("md_c1", MDS);
        cyc(); chk("md_c2", MDS);
        cyc(); chk("md_c3", MDS);
        cyc(); chk("md_c4_done", BUSY | DONE);
        cyc(); bus.md_start_Ex = 1'b0; chk("md_back_run", NONE);

        // Mult/div with freeze at the md_cnt==0 cycle
        cyc(); bus.md_start_Ex = 1'b1; chk("mdf_c1", MDS);
        cyc(); bus.md_start_Ex = 1'b0; chk("mdf_c2", MDS);
        cyc(); chk("mdf_c3", MDS);
        cyc(); bus.mem_req_Mem = 1'b1; bus.mem_ready = 1'b0; chk("mdf_frz1", FRZ | BUSY);
        cyc(); chk("mdf_frz2", FRZ | BUSY);
        cyc(); chk("mdf_frz3", FRZ | BUSY);
        cyc(); bus.mem_ready = 1'b1; chk("mdf_done", BUSY | DONE);
        cyc(); bus.mem_req_Mem = 1'b0; chk("mdf_run", NONE);

        // Freeze defers a taken branch; timeout on 4th consecutive freeze cycle
        cyc(); bus.Branch_taken_Ex = 1'b1; bus.mem_req_Mem = 1'b1; bus.mem_ready = 1'b0;
        chk("frz1", FRZ);
        cyc(); chk("frz2", FRZ);
        cyc(); chk("frz3", FRZ);
        cyc(); chk("to_rise", FRZ | TO);
        cyc(); chk("frz5", FRZ | TO);
        cyc(); bus.mem_ready = 1'b1; chk("release_redirect", RD | TO);
        cyc(); clr_in(); chk("to_sticky", TO);

        // Reset mid-MD at md_cnt==1
        cyc(); bus.md_start_Ex = 1'b1; chk("rmd_c1", MDS | TO);
        cyc(); bus.md_start_Ex = 1'b0; chk("rmd_c2", MDS | TO);
        cyc(); chk("rmd_c3", MDS | TO);
        #1; rst_n = 1'b0; chk("rst_mid_md", NONE);
        cyc(); rst_n = 1'b1; chk("post_rst1", NONE);
        cyc(); chk("post_rst2", NONE);
        cyc(); chk("post_rst3", NONE);
        cyc(); chk("post_rst4", NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
